// File: rtl/regfile_sb.sv
// regfile_sb -- parametrised register file with busy scoreboard.
//
// Two combinational read ports, one synchronous write port, synchronous
// active-high clear of all data and busy state, optional write-to-read
// bypass and an optional hardwired-zero register.
//
// Ports:
//   clk, reset                       clock / synchronous active-high clear
//   readRegister1/2 -> readData1/2   combinational read data
//                   -> readBusy1/2   combinational busy bit of the read reg
//   regWrite, writeRegister,
//   writeData                        write port (1-cycle latency); also
//                                    clears the busy bit of the target
//   reserve, reserveRegister         mark a register busy (pending producer)
//   anyBusy                          OR of all registered busy bits

// One read port: zero-register masking and optional bypass.
module regfile_sb_rdport #(
  parameter int               WIDTH  = 64,
  parameter int               ADDR_W = 5,
  parameter bit               ZEN    = 1'b1,
  parameter logic [ADDR_W-1:0] ZADDR = '0,
  parameter bit               BYP    = 1'b1
) (
  input  logic [ADDR_W-1:0]                    i_addr,
  input  logic [(1<<ADDR_W)-1:0][WIDTH-1:0]    i_regs,
  input  logic [(1<<ADDR_W)-1:0]               i_busy,
  input  logic                                 i_wr_en,
  input  logic [ADDR_W-1:0]                    i_wr_addr,
  input  logic [WIDTH-1:0]                     i_wr_data,
  output logic [WIDTH-1:0]                     o_data,
  output logic                                 o_busy
);
  logic w_is_zero;
  logic w_byp;

  assign w_is_zero = ZEN && (i_addr == ZADDR);
  // i_wr_en is already suppressed for the zero register, so the bypass
  // can never fire on it.
  assign w_byp     = BYP && i_wr_en && (i_addr == i_wr_addr);

  always_comb begin
    o_data = i_regs[i_addr];
    o_busy = i_busy[i_addr];
    if (w_is_zero) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (w_byp) begin
      o_data = i_wr_data;
      o_busy = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int ZERO_EN  = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readRegister1,
  input  logic [ADDR_W-1:0] readRegister2,
  output logic [WIDTH-1:0]  readData1,
  output logic [WIDTH-1:0]  readData2,
  output logic              readBusy1,
  output logic              readBusy2,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeRegister,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserveRegister,
  output logic              anyBusy
);
  localparam int                DEPTH  = 1 << ADDR_W;
  localparam int                NUM_RD = 2;
  localparam bit                ZEN    = (ZERO_EN != 0);
  localparam bit                BYP    = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] ZADDR  = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0][WIDTH-1:0] r_regs;
  logic [DEPTH-1:0]            r_busy;
  logic [DEPTH-1:0]            w_busy_nxt;
  logic                        w_wr_en;
  logic                        w_rsv_en;

  // Writes and reserves of the hardwired-zero register are dropped here,
  // so its storage and busy bit stay 0 from reset onward.
  assign w_wr_en  = regWrite && !(ZEN && (writeRegister == ZADDR));
  assign w_rsv_en = reserve  && !(ZEN && (reserveRegister == ZADDR));

  // Set after clear: a same-cycle reserve of the written register leaves
  // it busy, since the newly issued producer has not completed yet.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_en)  w_busy_nxt[writeRegister]   = 1'b0;
    if (w_rsv_en) w_busy_nxt[reserveRegister] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_en) r_regs[writeRegister] <= writeData;
      r_busy <= w_busy_nxt;
    end
  end

  assign anyBusy = |r_busy;

  logic [NUM_RD-1:0][ADDR_W-1:0] w_raddr;
  logic [NUM_RD-1:0][WIDTH-1:0]  w_rdata;
  logic [NUM_RD-1:0]             w_rbusy;

  assign w_raddr[0] = readRegister1;
  assign w_raddr[1] = readRegister2;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_sb_rdport #(
      .WIDTH (WIDTH),
      .ADDR_W(ADDR_W),
      .ZEN   (ZEN),
      .ZADDR (ZADDR),
      .BYP   (BYP)
    ) u_rd (
      .i_addr   (w_raddr[p]),
      .i_regs   (r_regs),
      .i_busy   (r_busy),
      .i_wr_en  (w_wr_en),
      .i_wr_addr(writeRegister),
      .i_wr_data(writeData),
      .o_data   (w_rdata[p]),
      .o_busy   (w_rbusy[p])
    );
  end

  assign readData1 = w_rdata[0];
  assign readData2 = w_rdata[1];
  assign readBusy1 = w_rbusy[0];
  assign readBusy2 = w_rbusy[1];
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---- default instance: 64x32, zero reg 31, bypass on
  logic        rst, we, rsv, b1, b2, any;
  logic [4:0]  wa, ra, a1, a2;
  logic [63:0] wd, d1, d2;

  regfile_sb u_dut (
    .clk(clk), .reset(rst),
    .readRegister1(a1), .readRegister2(a2),
    .readData1(d1), .readData2(d2),
    .readBusy1(b1), .readBusy2(b2),
    .regWrite(we), .writeRegister(wa), .writeData(wd),
    .reserve(rsv), .reserveRegister(ra),
    .anyBusy(any)
  );

  // ---- no-bypass instance
  logic        nb_rst, nb_we, nb_rsv, nb_b1, nb_b2, nb_any;
  logic [4:0]  nb_wa, nb_ra, nb_a1, nb_a2;
  logic [63:0] nb_wd, nb_d1, nb_d2;

  regfile_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(nb_rst),
    .readRegister1(nb_a1), .readRegister2(nb_a2),
    .readData1(nb_d1), .readData2(nb_d2),
    .readBusy1(nb_b1), .readBusy2(nb_b2),
    .regWrite(nb_we), .writeRegister(nb_wa), .writeData(nb_wd),
    .reserve(nb_rsv), .reserveRegister(nb_ra),
    .anyBusy(nb_any)
  );

  // ---- swept instance: 32-bit, 16 regs, no zero register
  logic        sw_rst, sw_we, sw_rsv, sw_b1, sw_b2, sw_any;
  logic [3:0]  sw_wa, sw_ra, sw_a1, sw_a2;
  logic [31:0] sw_wd, sw_d1, sw_d2;

  regfile_sb #(.WIDTH(32), .ADDR_W(4), .ZERO_EN(0)) u_sw (
    .clk(clk), .reset(sw_rst),
    .readRegister1(sw_a1), .readRegister2(sw_a2),
    .readData1(sw_d1), .readData2(sw_d2),
    .readBusy1(sw_b1), .readBusy2(sw_b2),
    .regWrite(sw_we), .writeRegister(sw_wa), .writeData(sw_wd),
    .reserve(sw_rsv), .reserveRegister(sw_ra),
    .anyBusy(sw_any)
  );

  typedef struct {
    logic        rst, we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        rsv;
    logic [4:0]  ra, a1, a2;
    logic [63:0] e1, e2;
    logic        eb1, eb2, eany;
  } vec_t;

  function automatic vec_t mkv(logic r, logic w, logic [4:0] wad, logic [63:0] wdat,
                               logic rs, logic [4:0] rad, logic [4:0] p1, logic [4:0] p2,
                               logic [63:0] x1, logic [63:0] x2,
                               logic xb1, logic xb2, logic xany);
    vec_t v;
    v.rst = r; v.we = w; v.wa = wad; v.wd = wdat; v.rsv = rs; v.ra = rad;
    v.a1 = p1; v.a2 = p2; v.e1 = x1; v.e2 = x2;
    v.eb1 = xb1; v.eb2 = xb2; v.eany = xany;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  localparam logic [63:0] DB = 64'hDEADBEEF_00000001;
  localparam logic [63:0] F1 = 64'hFFFFFFFF_FFFFFFFF;

  vec_t tv[21];

  initial begin
    // Expected values are the combinational outputs sampled before the
    // rising edge that commits this vector's write/reserve/reset.
    //             rst we wa     wd          rsv ra    a1     a2     e1     e2     b1 b2 any
    tv[0]  = mkv(0, 1, 5'd3,  DB,         0, 5'd0,  5'd3,  5'd3,  DB,    DB,    0, 0, 0);
    tv[1]  = mkv(1, 0, 5'd0,  64'h0,      0, 5'd0,  5'd3,  5'd0,  DB,    64'h0, 0, 0, 0);
    tv[2]  = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd3,  5'd3,  64'h0, 64'h0, 0, 0, 0);
    tv[3]  = mkv(0, 1, 5'd5,  64'hAA,     0, 5'd0,  5'd3,  5'd5,  64'h0, 64'hAA,0, 0, 0);
    tv[4]  = mkv(0, 1, 5'd31, 64'hFF,     0, 5'd0,  5'd31, 5'd5,  64'h0, 64'hAA,0, 0, 0);
    tv[5]  = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd31, 5'd31, 64'h0, 64'h0, 0, 0, 0);
    tv[6]  = mkv(0, 0, 5'd0,  64'h0,      1, 5'd31, 5'd31, 5'd5,  64'h0, 64'hAA,0, 0, 0);
    tv[7]  = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd31, 5'd5,  64'h0, 64'hAA,0, 0, 0);
    tv[8]  = mkv(0, 0, 5'd0,  64'h0,      1, 5'd9,  5'd9,  5'd9,  64'h0, 64'h0, 0, 0, 0);
    tv[9]  = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd9,  5'd9,  64'h0, 64'h0, 1, 1, 1);
    tv[10] = mkv(0, 0, 5'd0,  64'h0,      1, 5'd9,  5'd9,  5'd5,  64'h0, 64'hAA,1, 0, 1);
    tv[11] = mkv(0, 1, 5'd9,  64'h99,     0, 5'd0,  5'd9,  5'd5,  64'h99,64'hAA,0, 0, 1);
    tv[12] = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd9,  5'd9,  64'h99,64'h99,0, 0, 0);
    tv[13] = mkv(0, 1, 5'd12, 64'h55,     1, 5'd12, 5'd12, 5'd12, 64'h55,64'h55,0, 0, 0);
    tv[14] = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd12, 5'd12, 64'h55,64'h55,1, 1, 1);
    tv[15] = mkv(0, 1, 5'd12, 64'h66,     1, 5'd20, 5'd20, 5'd12, 64'h0, 64'h66,0, 0, 1);
    tv[16] = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd20, 5'd12, 64'h0, 64'h66,1, 0, 1);
    tv[17] = mkv(1, 1, 5'd20, 64'h77,     1, 5'd7,  5'd20, 5'd12, 64'h77,64'h66,0, 0, 1);
    tv[18] = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd20, 5'd7,  64'h0, 64'h0, 0, 0, 0);
    tv[19] = mkv(0, 1, 5'd0,  F1,         0, 5'd0,  5'd0,  5'd1,  F1,    64'h0, 0, 0, 0);
    tv[20] = mkv(0, 0, 5'd0,  64'h0,      0, 5'd0,  5'd0,  5'd0,  F1,    F1,    0, 0, 0);

    rst = 1; we = 0; wa = 0; wd = 0; rsv = 0; ra = 0; a1 = 0; a2 = 0;
    nb_rst = 1; nb_we = 0; nb_wa = 0; nb_wd = 0; nb_rsv = 0; nb_ra = 0; nb_a1 = 0; nb_a2 = 0;
    sw_rst = 1; sw_we = 0; sw_wa = 0; sw_wd = 0; sw_rsv = 0; sw_ra = 0; sw_a1 = 0; sw_a2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; nb_rst = 0; sw_rst = 0;
    a1 = 5'd3; a2 = 5'd17;
    #2;
    chk("reset_d1", d1, 64'h0);
    chk("reset_d2", d2, 64'h0);
    chk("reset_busy", {61'h0, b1, b2, any}, 64'h0);

    // ---- table-driven vectors on the default instance
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst = tv[i].rst; we = tv[i].we; wa = tv[i].wa; wd = tv[i].wd;
      rsv = tv[i].rsv; ra = tv[i].ra; a1 = tv[i].a1; a2 = tv[i].a2;
      #2;
      n_vec++;
      if (d1 !== tv[i].e1 || d2 !== tv[i].e2 || b1 !== tv[i].eb1 ||
          b2 !== tv[i].eb2 || any !== tv[i].eany) begin
        n_err++;
        $display("FAIL vec%0d: got d1=%h d2=%h b1=%b b2=%b any=%b want d1=%h d2=%h b1=%b b2=%b any=%b",
                 i, d1, d2, b1, b2, any, tv[i].e1, tv[i].e2, tv[i].eb1, tv[i].eb2, tv[i].eany);
      end
    end
    @(negedge clk);
    rst = 0; we = 0; rsv = 0;

    // ---- no-bypass: 1-cycle write latency, busy clears only after the edge
    nb_rsv = 1; nb_ra = 5'd7; nb_a1 = 5'd7; nb_a2 = 5'd7;
    @(negedge clk);
    nb_rsv = 0;
    nb_we = 1; nb_wa = 5'd7; nb_wd = 64'h1234;
    #2;
    chk("nb_old_data", nb_d1, 64'h0);
    chk("nb_still_busy", {62'h0, nb_b2, nb_any}, 64'h3);
    @(negedge clk);
    nb_we = 0;
    #2;
    chk("nb_new_data", nb_d1, 64'h1234);
    chk("nb_busy_clr", {62'h0, nb_b1, nb_any}, 64'h0);

    // ---- swept instance: all 16 registers, reg 15 writable, no aliasing
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sw_we = 1; sw_wa = 4'(i); sw_wd = 32'hA5A50000 + 32'(i);
    end
    @(negedge clk);
    sw_we = 0;
    for (int i = 0; i < 16; i++) begin
      sw_a1 = 4'(i); sw_a2 = 4'(15 - i);
      #1;
      chk($sformatf("sw_p1_r%0d", i), {32'h0, sw_d1}, {32'h0, 32'hA5A50000 + 32'(i)});
      chk($sformatf("sw_p2_r%0d", 15 - i), {32'h0, sw_d2}, {32'h0, 32'hA5A50000 + 32'(15 - i)});
    end
    // reg 15 is an ordinary busy-capable register here
    @(negedge clk);
    sw_rsv = 1; sw_ra = 4'd15;
    @(negedge clk);
    sw_rsv = 0; sw_a1 = 4'd15;
    #2;
    chk("sw_r15_busy", {62'h0, sw_b1, sw_any}, 64'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
